// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the sram arbiter: FSM state codes and transaction owner.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter_arb2_rr.sv
// Two-way IF/MEM grant, round-robin or MEM-first; combinational grant, registered last-grant.
// Grants only what is requested; a tie goes to MEM in fixed mode, else to whoever was not granted last.
module sram_arbiter_arb2_rr
  import sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fixed_pri,
  input  logic req_if,
  input  logic req_mem,
  output logic gnt_if,
  output logic gnt_mem
);

  owner_e last_grant_q;
  owner_e last_grant_d;
  logic   mem_wins;

  always_comb begin
    mem_wins     = req_mem && (!req_if || fixed_pri || (last_grant_q == OWN_IF));
    gnt_mem      = mem_wins;
    gnt_if       = req_if && !mem_wins;
    last_grant_d = last_grant_q;
    if (gnt_mem) begin
      last_grant_d = OWN_MEM;
    end else if (gnt_if) begin
      last_grant_d = OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= OWN_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one registered-read sram port between IF and MEM, one transaction at a time.
// Request accepted at T drives sram at T+1 and responds at T+3; the response is held until the owner takes it.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [DATA_W-1:0]     if_rsp_rdata,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  logic [ADDR_W-1:0]     mem_req_addr,
  input  logic [DATA_W/8-1:0]   mem_req_we,
  input  logic [DATA_W-1:0]     mem_req_wdata,
  output logic                  mem_rsp_valid,
  input  logic                  mem_rsp_ready,
  output logic [DATA_W-1:0]     mem_rsp_rdata,
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sram_en_q, sram_en_d;
  logic [BE_W-1:0]   sram_we_q, sram_we_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              mem_rsp_valid_q, mem_rsp_valid_d;

  logic idle;
  logic gnt_if;
  logic gnt_mem;
  logic rsp_done;

  // Gating with rst_n keeps both readies low while reset is held, even in IDLE.
  assign idle = (state_q == ST_IDLE) && rst_n;

  sram_arbiter_arb2_rr u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .fixed_pri (FIXED_PRI != 0),
    .req_if    (if_req_valid && idle),
    .req_mem   (mem_req_valid && idle),
    .gnt_if    (gnt_if),
    .gnt_mem   (gnt_mem)
  );

  assign rsp_done = (owner_q == OWN_IF) ? if_rsp_ready : mem_rsp_ready;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    sram_en_d       = 1'b0;
    sram_we_d       = '0;
    if_rsp_valid_d  = if_rsp_valid_q;
    mem_rsp_valid_d = mem_rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_mem) begin
          owner_d = OWN_MEM;
          addr_d  = mem_req_addr;
          we_d    = mem_req_we;
          wdata_d = mem_req_wdata;
        end else if (gnt_if) begin
          owner_d = OWN_IF;
          addr_d  = if_req_addr;
          we_d    = '0;
          wdata_d = '0;
        end
        if (gnt_mem || gnt_if) begin
          state_d   = ST_ISSUE;
          sram_en_d = 1'b1;
          sram_we_d = we_d;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Writes return zero data so the MEM side sees a clean ack.
        rdata_d         = (we_q == '0) ? sram_rdata : '0;
        if_rsp_valid_d  = (owner_q == OWN_IF);
        mem_rsp_valid_d = (owner_q == OWN_MEM);
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_done) begin
          if_rsp_valid_d  = 1'b0;
          mem_rsp_valid_d = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IF;
      addr_q          <= '0;
      we_q            <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      sram_en_q       <= 1'b0;
      sram_we_q       <= '0;
      if_rsp_valid_q  <= 1'b0;
      mem_rsp_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      sram_en_q       <= sram_en_d;
      sram_we_q       <= sram_we_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      mem_rsp_valid_q <= mem_rsp_valid_d;
    end
  end

  assign if_req_ready  = gnt_if;
  assign mem_req_ready = gnt_mem;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign mem_rsp_valid = mem_rsp_valid_q;
  assign if_rsp_rdata  = rdata_q;
  assign mem_rsp_rdata = rdata_q;
  assign sram_en       = sram_en_q;
  assign sram_we       = sram_we_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: round-robin instance (dut0) and MEM-first instance (dut1) on shared stimulus.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_rsp_ready;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_we;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_ready;

  logic        if_req_ready0, if_rsp_valid0, mem_req_ready0, mem_rsp_valid0, sram_en0;
  logic [63:0] if_rsp_rdata0, mem_rsp_rdata0, sram_addr0, sram_wdata0, rd0;
  logic [7:0]  sram_we0;
  logic        if_req_ready1, if_rsp_valid1, mem_req_ready1, mem_rsp_valid1, sram_en1;
  logic [63:0] if_rsp_rdata1, mem_rsp_rdata1, sram_addr1, sram_wdata1, rd1;
  logic [7:0]  sram_we1;

  logic [63:0] mem0 [16];
  logic [63:0] mem1 [16];
  logic        load;
  logic [3:0]  load_idx;
  logic [63:0] load_dat;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRI(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready0), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid0), .if_rsp_ready(if_rsp_ready), .if_rsp_rdata(if_rsp_rdata0),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready0), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid0), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata0),
    .sram_en(sram_en0), .sram_we(sram_we0), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
    .sram_rdata(rd0)
  );

  sram_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRI(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready1), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid1), .if_rsp_ready(if_rsp_ready), .if_rsp_rdata(if_rsp_rdata1),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready1), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid1), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata1),
    .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
    .sram_rdata(rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sram per instance: byte-masked write, read data registered (old contents).
  always @(posedge clk) begin
    if (load) begin
      mem0[load_idx] <= load_dat;
      mem1[load_idx] <= load_dat;
    end
    if (sram_en0) begin
      rd0 <= mem0[sram_addr0[6:3]];
      for (int b = 0; b < 8; b++)
        if (sram_we0[b]) mem0[sram_addr0[6:3]][b*8 +: 8] <= sram_wdata0[b*8 +: 8];
    end
    if (sram_en1) begin
      rd1 <= mem1[sram_addr1[6:3]];
      for (int b = 0; b < 8; b++)
        if (sram_we1[b]) mem1[sram_addr1[6:3]][b*8 +: 8] <= sram_wdata1[b*8 +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0] addrs [4];
  logic [63:0] words [4];
  logic [2:0]  exp_mem0;
  int          en_cyc [$];
  logic [63:0] en_addr [$];
  logic [63:0] rsp_dat [$];
  int          idx;
  int          rsp_cnt;
  logic        acc;

  initial begin
    rst_n = 1'b0; load = 1'b0; load_idx = '0; load_dat = '0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008; if_rsp_ready = 1'b1;
    mem_req_valid = 1'b1; mem_req_addr = 64'h8000_0010; mem_req_we = 8'h00;
    mem_req_wdata = '0; mem_rsp_ready = 1'b1;
    words[0] = 64'hA0A1_A2A3_A4A5_A6A7;
    words[1] = 64'h1122_3344_5566_7788;
    words[2] = 64'h0123_4567_89AB_CDEF;
    words[3] = 64'hB3B2_B1B0_C3C2_C1C0;
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_idx = 4'(i); load_dat = words[i];
      step();
    end
    load = 1'b0;
    step();

    // Reset state, with both requesters pushing
    chk("rst_if_req_ready", if_req_ready0, 0);
    chk("rst_mem_req_ready", mem_req_ready0, 0);
    chk("rst_if_rsp_valid", if_rsp_valid0, 0);
    chk("rst_mem_rsp_valid", mem_rsp_valid0, 0);
    chk("rst_sram_en", sram_en0, 0);
    chk("rst_sram_we", sram_we0, 0);
    chk("rst_sram_addr", sram_addr0, 0);
    chk("rst_sram_wdata", sram_wdata0, 0);
    chk("rst_rdata", if_rsp_rdata0, 0);
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Lone IF read
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    #1;
    chk("if_ready_alone", if_req_ready0, 1);
    chk("mem_ready_alone", mem_req_ready0, 0);
    step();
    if_req_valid = 1'b0;
    chk("if_rd_en_t1", sram_en0, 1);
    chk("if_rd_we_t1", sram_we0, 0);
    chk("if_rd_addr_t1", sram_addr0, 64'h8000_0008);
    step();
    chk("if_rd_en_t2", sram_en0, 0);
    chk("if_rd_vld_t2", if_rsp_valid0, 0);
    step();
    chk("if_rd_vld_t3", if_rsp_valid0, 1);
    chk("if_rd_data_t3", if_rsp_rdata0, 64'h1122_3344_5566_7788);
    chk("if_rd_memvld_t3", mem_rsp_valid0, 0);
    step();
    chk("if_rd_vld_t4", if_rsp_valid0, 0);

    // MEM partial write with a stalled response, IF waiting behind it
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1; mem_req_addr = 64'h8000_0010;
    mem_req_we = 8'h0F; mem_req_wdata = 64'h0000_0000_A5A5_A5A5;
    #1;
    chk("wr_mem_ready", mem_req_ready0, 1);
    step();
    mem_req_valid = 1'b0; mem_req_we = 8'h00; mem_req_wdata = '0;
    chk("wr_sram_en", sram_en0, 1);
    chk("wr_sram_we", sram_we0, 8'h0F);
    chk("wr_sram_wdata", sram_wdata0, 64'h0000_0000_A5A5_A5A5);
    step();
    step();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_mem_vld", mem_rsp_valid0, 1);
      chk("stall_mem_rdata", mem_rsp_rdata0, 0);
      chk("stall_sram_en", sram_en0, 0);
      chk("stall_if_ready", if_req_ready0, 0);
      step();
    end
    mem_rsp_ready = 1'b1;
    #1;
    chk("stall_release_vld", mem_rsp_valid0, 1);
    step();
    chk("wr_done_vld", mem_rsp_valid0, 0);
    #1;
    chk("rdback_if_ready", if_req_ready0, 1);
    step();
    if_req_valid = 1'b0;
    chk("rdback_addr", sram_addr0, 64'h8000_0010);
    step();
    step();
    chk("rdback_vld", if_rsp_valid0, 1);
    chk("rdback_data", if_rsp_rdata0, 64'h0123_4567_A5A5_A5A5);
    step();

    // Three back-to-back ties (both reads); last grant so far was IF
    exp_mem0 = 3'b101;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    mem_req_valid = 1'b1; mem_req_addr = 64'h8000_0010;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("tie_rr_mem_ready", mem_req_ready0, exp_mem0[g]);
      chk("tie_rr_if_ready", if_req_ready0, !exp_mem0[g]);
      chk("tie_fix_mem_ready", mem_req_ready1, 1);
      chk("tie_fix_if_ready", if_req_ready1, 0);
      step();
      if (g == 2) begin
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
      end
      step();
      step();
      if (g == 1) begin
        chk("tie_rr_if_rsp", if_rsp_valid0, 1);
        chk("tie_rr_if_data", if_rsp_rdata0, 64'h1122_3344_5566_7788);
      end
      step();
    end

    // Reset during CAPTURE drops the transaction
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    step();
    if_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_if_vld", if_rsp_valid0, 0);
    chk("mid_rst_mem_vld", mem_rsp_valid0, 0);
    chk("mid_rst_en", sram_en0, 0);
    chk("mid_rst_addr", sram_addr0, 0);
    chk("mid_rst_rdata", if_rsp_rdata0, 0);
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (if_rsp_valid0 || mem_rsp_valid0) rsp_cnt++;
    end
    chk("mid_rst_no_rsp", 64'(rsp_cnt), 0);
    chk("mid_rst_idle_ready", if_req_ready0, 0);

    // Back-to-back IF reads, always-ready consumer
    addrs[0] = 64'h8000_0000; addrs[1] = 64'h8000_0008;
    addrs[2] = 64'h8000_0010; addrs[3] = 64'h8000_0018;
    idx = 0;
    if_req_valid = 1'b1; if_req_addr = addrs[0];
    for (int c = 0; c < 20; c++) begin
      #1;
      acc = if_req_ready0;
      step();
      if (sram_en0) begin
        en_cyc.push_back(c);
        en_addr.push_back(sram_addr0);
      end
      if (if_rsp_valid0 && if_rsp_ready) rsp_dat.push_back(if_rsp_rdata0);
      if (acc) begin
        idx++;
        if (idx < 4) if_req_addr = addrs[idx];
        else if_req_valid = 1'b0;
      end
    end
    chk("b2b_en_count", 64'(en_cyc.size()), 4);
    chk("b2b_rsp_count", 64'(rsp_dat.size()), 4);
    words[2] = 64'h0123_4567_A5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      if (i < en_cyc.size()) begin
        chk("b2b_en_cycle", 64'(en_cyc[i]), 64'(4 * i));
        chk("b2b_addr", en_addr[i], addrs[i]);
      end
      if (i < rsp_dat.size()) chk("b2b_rdata", rsp_dat[i], words[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
